// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: USB full-speed receive line decoder.
// Synchronizes D+/D-, NRZI-decodes on each bit strobe, removes stuffed bits
// and recognises end-of-packet (SE0,SE0,J).
// Optional feature macro: USB_RX_STUFF_ERR_EN (flags a 1 in the stuff-bit slot).
module usb_rx_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int STUFF_LEN   = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_in,
  input  logic d_minus_in,
  input  logic shift_enable,
  output logic d_edge,
  output logic d_orig,
  output logic bit_valid,
  output logic eop,
  output logic line_err,
  output logic stuff_err
);

  localparam int CW = $clog2(STUFF_LEN + 1);

  typedef enum logic [1:0] {IDLE, RECV, SE0A, SE0B} state_t;

  logic [SYNC_STAGES-1:0] dp_chain_q, dm_chain_q;
  logic                   dp_sync, dm_sync;
  logic                   dp_sync_q, d_edge_q, d_edge_d;
  state_t                 state_q, state_d;
  logic                   prev_dp_q, prev_dp_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   d_orig_q, d_orig_d;
  logic                   bit_valid_q, bit_valid_d;
  logic                   eop_q, eop_d;
  logic                   line_err_q, line_err_d;
  logic                   stuff_err_q, stuff_err_d;
  logic                   is_j, is_k, is_se0, nrzi_bit;

  // Input synchronizer chains; reset value is the idle J state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_chain_q <= '1;
      dm_chain_q <= '0;
    end else begin
      dp_chain_q <= {dp_chain_q[SYNC_STAGES-2:0], d_plus_in};
      dm_chain_q <= {dm_chain_q[SYNC_STAGES-2:0], d_minus_in};
    end
  end

  assign dp_sync  = dp_chain_q[SYNC_STAGES-1];
  assign dm_sync  = dm_chain_q[SYNC_STAGES-1];
  assign is_j     = dp_sync & ~dm_sync;
  assign is_k     = ~dp_sync & dm_sync;
  assign is_se0   = ~dp_sync & ~dm_sync;
  assign nrzi_bit = (dp_sync == prev_dp_q);
  assign d_edge_d = dp_sync ^ dp_sync_q;

  // Decoder next-state: everything advances only on the bit strobe
  always_comb begin
    state_d     = state_q;
    prev_dp_d   = prev_dp_q;
    cnt_d       = cnt_q;
    d_orig_d    = d_orig_q;
    bit_valid_d = 1'b0;
    eop_d       = 1'b0;
    line_err_d  = 1'b0;
    stuff_err_d = 1'b0;
    if (shift_enable) begin
      case (state_q)
        IDLE: begin
          prev_dp_d = 1'b1;
          cnt_d     = '0;
          if (is_k) begin
            bit_valid_d = 1'b1;
            d_orig_d    = 1'b0;
            prev_dp_d   = 1'b0;
            state_d     = RECV;
          end else if (!is_j && !is_se0) begin
            line_err_d = 1'b1;
          end
        end
        RECV: begin
          if (is_j || is_k) begin
            prev_dp_d = dp_sync;
            if (cnt_q == CW'(STUFF_LEN)) begin
              // Stuff slot: the sample is consumed without producing a bit
              cnt_d = '0;
`ifdef USB_RX_STUFF_ERR_EN
              if (nrzi_bit) begin
                stuff_err_d = 1'b1;
                prev_dp_d   = 1'b1;
                state_d     = IDLE;
              end
`endif
            end else begin
              bit_valid_d = 1'b1;
              d_orig_d    = nrzi_bit;
              cnt_d       = nrzi_bit ? CW'(cnt_q + 1'b1) : '0;
            end
          end else if (is_se0) begin
            cnt_d   = '0;
            state_d = SE0A;
          end else begin
            line_err_d = 1'b1;
            prev_dp_d  = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end
        end
        SE0A: begin
          if (is_se0) begin
            state_d = SE0B;
          end else begin
            line_err_d = 1'b1;
            prev_dp_d  = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end
        end
        default: begin
          // SE0B: a long SE0 is tolerated, J closes the packet
          if (!is_se0) begin
            eop_d      = is_j;
            line_err_d = ~is_j;
            prev_dp_d  = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_sync_q   <= 1'b1;
      d_edge_q    <= 1'b0;
      state_q     <= IDLE;
      prev_dp_q   <= 1'b1;
      cnt_q       <= '0;
      d_orig_q    <= 1'b1;
      bit_valid_q <= 1'b0;
      eop_q       <= 1'b0;
      line_err_q  <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      dp_sync_q   <= dp_sync;
      d_edge_q    <= d_edge_d;
      state_q     <= state_d;
      prev_dp_q   <= prev_dp_d;
      cnt_q       <= cnt_d;
      d_orig_q    <= d_orig_d;
      bit_valid_q <= bit_valid_d;
      eop_q       <= eop_d;
      line_err_q  <= line_err_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign d_edge    = d_edge_q;
  assign d_orig    = d_orig_q;
  assign bit_valid = bit_valid_q;
  assign eop       = eop_q;
  assign line_err  = line_err_q;
  assign stuff_err = stuff_err_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: table of line samples with expected pulses,
// checked through a scoreboard queue, plus a mid-packet reset sequence.
module tb_usb_rx_decoder;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic n_rst;
  logic d_plus_in, d_minus_in, shift_enable;
  logic d_edge, d_orig, bit_valid, eop, line_err, stuff_err;

  usb_rx_decoder #(.SYNC_STAGES(SYNC), .STUFF_LEN(6)) dut (
    .clk(clk), .n_rst(n_rst), .d_plus_in(d_plus_in), .d_minus_in(d_minus_in),
    .shift_enable(shift_enable), .d_edge(d_edge), .d_orig(d_orig),
    .bit_valid(bit_valid), .eop(eop), .line_err(line_err), .stuff_err(stuff_err)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, L0 = 2'b00, L1 = 2'b11;
  // expected {bit_valid, bit, eop, line_err, stuff_err}
  localparam logic [4:0] N = 5'b00000, B0 = 5'b10000, B1 = 5'b11000,
                         EP = 5'b00100, LE = 5'b00010, SE = 5'b00001;

  typedef struct { logic [1:0] ln; logic [4:0] ex; string name; } vec_t;
  typedef struct { logic [4:0] ex; string name; } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int total = 0, bad = 0;
  int edge_cnt = 0, exp_edges = 0, quiet_bad = 0;
  logic last_d = 1'b1;
  logic cur_dp = 1'b1;

  // Count d_edge pulses seen by the DUT
  always @(negedge clk) if (n_rst && d_edge) edge_cnt = edge_cnt + 1;

  task automatic add(input logic [1:0] ln, input logic [4:0] ex, input string name);
    vec_t v;
    v.ln = ln; v.ex = ex; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e, p;
    @(negedge clk);
    if (v.ln[1] != cur_dp) exp_edges++;
    cur_dp = v.ln[1];
    d_plus_in = v.ln[1];
    d_minus_in = v.ln[0];
    repeat (SYNC + 2) begin
      @(negedge clk);
      if (bit_valid | eop | line_err | stuff_err) quiet_bad++;
    end
    shift_enable = 1'b1;
    e.ex = v.ex;
    if (v.ex[4]) last_d = v.ex[3];
    e.ex[3] = last_d;
    e.name = v.name;
    sb.push_back(e);
    @(negedge clk);
    shift_enable = 1'b0;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      p = sb.pop_front();
      check(p.name, {1'b0, bit_valid, d_orig, eop, line_err, stuff_err}, {1'b0, p.ex});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; d_plus_in = 1'b1; d_minus_in = 1'b0; shift_enable = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("reset_state", {d_edge, d_orig, bit_valid, eop, line_err, stuff_err}, 6'b010000);

    for (int i = 0; i < 10; i++) add(LJ, N, "idle_j");
    // SYNC pattern KJKJKJKK then J,J, closed by EOP
    add(LK, B0, "sync0"); add(LJ, B0, "sync1"); add(LK, B0, "sync2"); add(LJ, B0, "sync3");
    add(LK, B0, "sync4"); add(LJ, B0, "sync5"); add(LK, B0, "sync6"); add(LK, B1, "sync7");
    add(LJ, B0, "pid0"); add(LJ, B1, "pid1");
    add(L0, N, "eop_se0a"); add(L0, N, "eop_se0b"); add(LJ, EP, "eop_j");
    // Six 1s followed by a legal stuff 0
    add(LK, B0, "st_k");
    for (int i = 0; i < 6; i++) add(LK, B1, "st_one");
    add(LJ, N, "st_drop"); add(LK, B0, "st_after");
    add(L0, N, "st_se0a"); add(L0, N, "st_se0b"); add(LJ, EP, "st_eop");
    // Six 1s followed by a seventh 1 in the stuff slot
    add(LK, B0, "sv_k");
    for (int i = 0; i < 6; i++) add(LK, B1, "sv_one");
`ifdef USB_RX_STUFF_ERR_EN
    add(LK, SE, "sv_err"); add(LK, B0, "sv_idle_k");
`else
    add(LK, N, "sv_drop"); add(LK, B1, "sv_next");
`endif
    add(L0, N, "sv_se0a"); add(L0, N, "sv_se0b"); add(LJ, EP, "sv_eop");
    // Malformed EOPs and SE1
    add(LK, B0, "m1_k"); add(L0, N, "m1_se0"); add(LK, LE, "m1_k_err"); add(LJ, N, "m1_idle");
    add(L1, LE, "se1_idle"); add(LJ, N, "se1_j");
    add(LK, B0, "m2_k"); add(L0, N, "m2_se0a"); add(L0, N, "m2_se0b"); add(LK, LE, "m2_k_err");
    add(LK, B0, "m3_k"); add(L1, LE, "m3_se1");
    add(LK, B0, "ls_k"); add(L0, N, "ls_se0a"); add(L0, N, "ls_se0b"); add(L0, N, "ls_se0c");
    add(LJ, EP, "ls_eop"); add(LJ, N, "ls_idle");

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    repeat (2) @(negedge clk);
    check("d_edge_count", 6'(edge_cnt), 6'(exp_edges));
    check("quiet_between_strobes", 6'(quiet_bad), 6'd0);
    check("scoreboard_drained", 6'(sb.size()), 6'd0);

    // Mid-packet reset: outputs return to reset values without a clock edge
    begin
      vec_t v;
      v.ln = LK; v.ex = B0; v.name = "rst_k"; apply(v);
      v.ln = LK; v.ex = B1; v.name = "rst_k1"; apply(v);
      #2 n_rst = 1'b0;
      #1 check("async_reset", {d_edge, d_orig, bit_valid, eop, line_err, stuff_err}, 6'b010000);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      last_d = 1'b1;
      v.ln = L0; v.ex = N; v.name = "rst_se0a"; apply(v);
      v.ln = L0; v.ex = N; v.name = "rst_se0b"; apply(v);
      v.ln = LJ; v.ex = N; v.name = "rst_no_eop"; apply(v);
      v.ln = LK; v.ex = B0; v.name = "rst_k_again"; apply(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
